debug_loader: RTL and testbench
===============================

# debug_loader

Host-facing control unit sitting directly upstream of the pipeline. Consumes bytes from the UART receiver, loads programs into instruction memory through the pipeline's `i_write_instruction_mem` / `i_instruction_mem_addr` / `i_instruction_mem_data` port, and drives the pipeline's `i_halt` for run, step and halt control. It answers each command with a status byte through the UART transmitter.

## Interface
Parameters
- `ACK`, 8'h06: success response byte.
- `NAK`, 8'h15: rejected or unknown command response byte.
- `END`, 8'h45: program-finished notification byte.

Ports
- `i_clk` input 1: single clock.
- `i_reset` input 1: reset, asynchronous and active-high.
- `i_rx_data` input 8: received byte.
- `i_rx_valid` input 1: one-cycle strobe; `i_rx_data` is valid this cycle.
- `i_tx_busy` input 1: transmitter busy; no start may be issued while high.
- `i_program_halted` input 1: level from the pipeline, high once a halt instruction has reached decode.
- `o_tx_data` output 8: byte to transmit; held stable from the start pulse until `i_tx_busy` falls.
- `o_tx_start` output 1: one-cycle transmit request.
- `o_write_instruction_mem` output 1: one-cycle instruction-memory write strobe.
- `o_instruction_mem_addr` output 32: byte address, always word-aligned (bits [1:0] = 0).
- `o_instruction_mem_data` output 32: word to write.
- `o_halt` output 1: pipeline freeze (1 = frozen).

## Operation
- Reset values:
  - `o_halt` = 1.
  - All other outputs = 0.
  - FSM in IDLE; byte, word and address counters = 0.
- Commands are single bytes and are decoded in IDLE only:
  - `8'h4C` (L, load): accepted only when `o_halt` = 1, otherwise respond NAK. Next byte is word count N: 1..255, with 0 meaning 256. Then 4N data bytes, little-endian (first byte goes to [7:0]). Word k is written to address 4k, starting at address 0. Respond ACK after the final write.
  - `8'h52` (R, run): `o_halt` ← 0. Respond ACK.
  - `8'h53` (S, step): `o_halt` = 0 for exactly one cycle, then back to 1. Respond ACK. If already running, respond NAK and leave `o_halt` unchanged.
  - `8'h48` (H, halt): `o_halt` ← 1. Respond ACK.
  - Any other byte: respond NAK; no other effect.
- States and transitions:
  - IDLE → LOAD_COUNT on L.
  - LOAD_COUNT → LOAD_DATA on the next `i_rx_valid`.
  - LOAD_DATA collects bytes using a 2-bit byte index and an 8-bit word counter.
  - On the 4th byte of a word: fire the write. If it was word N, go to SEND(ACK); otherwise stay in LOAD_DATA.
  - IDLE → STEP on S; STEP → SEND(ACK) after one cycle.
  - SEND issues the start, then returns to IDLE.
- SEND waits while `i_tx_busy` = 1. It pulses `o_tx_start` in the first cycle with `i_tx_busy` = 0, then returns to IDLE on the next cycle.
- `i_rx_valid` arriving while in SEND or STEP is dropped.
- Program end: in IDLE with `o_halt` = 0, a rising edge of `i_program_halted` sets `o_halt` ← 1 and enters SEND(END).
- If a command byte and a `i_program_halted` rising edge arrive in the same cycle, the halt event wins and the command byte is dropped.
- Assertion of `i_reset` at any point:
  - Aborts a load and discards any partial word.
  - Words already written stay in memory.
  - A pending response is dropped.
  - `o_halt` returns to 1.

## Timing
- Write strobe: `o_write_instruction_mem`, address and data are registered and asserted in the cycle after the `i_rx_valid` of the 4th byte, for exactly one cycle.
- Address/data hold: address and data remain stable until the next write.
- Response after final write: the final write and entry into SEND occur on the same edge. `o_tx_start` follows at the earliest one cycle later.
- R/H latency: `o_halt` changes on the edge after the command's `i_rx_valid`.
- S timing: `o_halt` = 0 in exactly the cycle after the S strobe, and = 1 again the cycle after that.
- Back-to-back data: bytes on consecutive cycles must be accepted in LOAD_DATA. No bubble is allowed between words.

## Test plan
- Load after reset: send 4C 02 78 56 34 12 EF BE AD DE.
  - Required: write addr 0 data 32'h12345678, then addr 4 data 32'hDEADBEEF, each one cycle wide.
  - Then one `o_tx_start` with `o_tx_data` = 06.
- Step: send 53 while halted.
  - Required: `o_halt` low for exactly 1 cycle, ACK sent.
  - With `i_tx_busy` held high for 20 cycles, `o_tx_start` is delayed until it falls.
- Run, then finish: send 52, then raise `i_program_halted`.
  - Required: ACK, `o_halt` = 0.
  - Then `o_halt` = 1 on the edge after the rise, and `o_tx_data` = 45 is sent.
- Rejected commands: send 4C while running, then byte 7A.
  - Required: two NAKs (15), no write strobe, `o_halt` unchanged.
- Reset mid-load: send 4C 01 AA BB, then pulse `i_reset` asynchronously between clock edges.
  - Required: outputs reset immediately with `o_halt` = 1 and no write.
  - A subsequent 4C 01 11 22 33 44 writes 32'h44332211 at address 0.
- Count 0: send 4C 00 followed by 1024 bytes.
  - Required: 256 writes, the last at address 32'h3FC, then ACK.

Source files
------------

// File: rtl/debug_loader_if.sv
// Host-side bus of the debug loader: UART rx/tx handshake, instruction-memory
// write port and pipeline freeze. master = debug_loader, slave = its environment.
interface debug_loader_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_tx_busy;
  logic        i_program_halted;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_write_instruction_mem;
  logic [31:0] o_instruction_mem_addr;
  logic [31:0] o_instruction_mem_data;
  logic        o_halt;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_busy, i_program_halted,
    output o_tx_data, o_tx_start, o_write_instruction_mem,
           o_instruction_mem_addr, o_instruction_mem_data, o_halt
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_busy, i_program_halted,
    input  o_tx_data, o_tx_start, o_write_instruction_mem,
           o_instruction_mem_addr, o_instruction_mem_data, o_halt
  );
endinterface

// File: rtl/debug_loader.sv
// Host command decoder: loads programs into instruction memory over UART and
// drives the pipeline freeze for run / step / halt, answering each command.
module debug_loader #(
  parameter logic [7:0] ACK = 8'h06,
  parameter logic [7:0] NAK = 8'h15,
  parameter logic [7:0] END = 8'h45
) (
  input  logic           i_clk,
  input  logic           i_reset,
  debug_loader_if.master bus
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_COUNT,
    LOAD_DATA,
    STEP,
    SEND
  } state_t;

  state_t      state_q, state_d;
  logic        halt_q, halt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  word_total_q, word_total_d;
  logic [23:0] partial_q, partial_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  resp_q, resp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        halted_prev_q;
  logic        halted_rise;

  assign halted_rise = bus.i_program_halted & ~halted_prev_q;

  // NOTE: every signal assigned below gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    halt_d       = halt_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    word_total_d = word_total_q;
    partial_d    = partial_q;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_d       = resp_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A program finishing takes priority over a command in the same cycle.
        if (halted_rise && !halt_q) begin
          halt_d  = 1'b1;
          resp_d  = END;
          state_d = SEND;
        end else if (bus.i_rx_valid) begin
          resp_d  = NAK;
          state_d = SEND;
          case (bus.i_rx_data)
            CMD_LOAD: if (halt_q) state_d = LOAD_COUNT;
            CMD_RUN: begin
              halt_d = 1'b0;
              resp_d = ACK;
            end
            CMD_STEP: if (halt_q) begin
              halt_d  = 1'b0;
              state_d = STEP;
            end
            CMD_HALT: begin
              halt_d = 1'b1;
              resp_d = ACK;
            end
            default: ;
          endcase
        end
      end

      LOAD_COUNT: if (bus.i_rx_valid) begin
        // A count of 0 wraps to 256 words through the 8-bit compare below.
        word_total_d = bus.i_rx_data;
        word_cnt_d   = 8'd0;
        byte_idx_d   = 2'd0;
        state_d      = LOAD_DATA;
      end

      LOAD_DATA: if (bus.i_rx_valid) begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          wr_d       = 1'b1;
          addr_d     = {22'd0, word_cnt_q, 2'b00};
          data_d     = {bus.i_rx_data, partial_q};
          word_cnt_d = word_cnt_q + 8'd1;
          if (word_cnt_q == word_total_q - 8'd1) begin
            resp_d  = ACK;
            state_d = SEND;
          end
        end else begin
          // Little-endian: earlier bytes shift down toward bit 0.
          partial_d = {bus.i_rx_data, partial_q[23:8]};
        end
      end

      STEP: begin
        halt_d  = 1'b1;
        resp_d  = ACK;
        state_d = SEND;
      end

      SEND: if (!bus.i_tx_busy) begin
        // tx_data only changes here, so it stays put while the previous byte is on the wire.
        tx_start_d = 1'b1;
        tx_data_d  = resp_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      halt_q        <= 1'b1;
      byte_idx_q    <= 2'd0;
      word_cnt_q    <= 8'd0;
      word_total_q  <= 8'd0;
      partial_q     <= 24'd0;
      wr_q          <= 1'b0;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      resp_q        <= 8'd0;
      tx_data_q     <= 8'd0;
      tx_start_q    <= 1'b0;
      halted_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      byte_idx_q    <= byte_idx_d;
      word_cnt_q    <= word_cnt_d;
      word_total_q  <= word_total_d;
      partial_q     <= partial_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      resp_q        <= resp_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      halted_prev_q <= bus.i_program_halted;
    end
  end

  assign bus.o_halt                  = halt_q;
  assign bus.o_write_instruction_mem = wr_q;
  assign bus.o_instruction_mem_addr  = addr_q;
  assign bus.o_instruction_mem_data  = data_q;
  assign bus.o_tx_data               = tx_data_q;
  assign bus.o_tx_start              = tx_start_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed bench for debug_loader: expected writes and response bytes are queued
// when stimulus is driven and compared by a monitor as the DUT produces them.
module tb_debug_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_loader_if dl();

  debug_loader dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (dl)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_tx_q[$];
  logic        busy_at_edge = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Busy as the DUT saw it at the edge that launched a start.
  always @(posedge clk) busy_at_edge <= dl.i_tx_busy;

  always @(negedge clk) begin
    if (dl.o_write_instruction_mem === 1'b1) begin
      writes++;
      check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        check("write_addr", dl.o_instruction_mem_addr, exp_addr_q.pop_front());
        check("write_data", dl.o_instruction_mem_data, exp_data_q.pop_front());
      end
    end
    if (dl.o_tx_start === 1'b1) begin
      check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
      check("tx_start_while_busy", 32'(busy_at_edge), 32'd0);
      if (exp_tx_q.size() != 0)
        check("tx_data", 32'(dl.o_tx_data), 32'(exp_tx_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    dl.i_rx_data  = b;
    dl.i_rx_valid = 1'b1;
    @(negedge clk);
    dl.i_rx_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_tx_q.size() != 0 || exp_addr_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_tx_q.size() + exp_addr_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] words[256];

    rst                 = 1'b1;
    dl.i_rx_data        = 8'd0;
    dl.i_rx_valid       = 1'b0;
    dl.i_tx_busy        = 1'b0;
    dl.i_program_halted = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_halt",     32'(dl.o_halt), 32'd1);
    check("reset_tx_start", 32'(dl.o_tx_start), 32'd0);
    check("reset_tx_data",  32'(dl.o_tx_data), 32'd0);
    check("reset_write",    32'(dl.o_write_instruction_mem), 32'd0);
    check("reset_addr",     dl.o_instruction_mem_addr, 32'd0);
    check("reset_data",     dl.o_instruction_mem_data, 32'd0);

    // Two-word load, bytes back to back.
    expect_write(32'h0, 32'h12345678);
    expect_write(32'h4, 32'hDEADBEEF);
    exp_tx_q.push_back(8'h06);
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_done("load2_done");

    // Single step with the transmitter busy for 20 cycles.
    dl.i_tx_busy = 1'b1;
    exp_tx_q.push_back(8'h06);
    send_byte(8'h53);
    check("step_halt_low", 32'(dl.o_halt), 32'd0);
    @(negedge clk);
    check("step_halt_back", 32'(dl.o_halt), 32'd1);
    repeat (18) @(negedge clk);
    check("step_tx_held", 32'(exp_tx_q.size()), 32'd1);
    dl.i_tx_busy = 1'b0;
    wait_done("step_done");

    // Run, then the program finishes.
    exp_tx_q.push_back(8'h06);
    send_byte(8'h52);
    check("run_halt_low", 32'(dl.o_halt), 32'd0);
    wait_done("run_done");
    check("run_still_running", 32'(dl.o_halt), 32'd0);
    exp_tx_q.push_back(8'h45);
    dl.i_program_halted = 1'b1;
    @(negedge clk);
    check("end_halt_high", 32'(dl.o_halt), 32'd1);
    wait_done("end_done");
    dl.i_program_halted = 1'b0;

    // Rejected commands while running.
    exp_tx_q.push_back(8'h06);
    send_byte(8'h52);
    wait_done("run2_done");
    exp_tx_q.push_back(8'h15);
    send_byte(8'h4C);
    wait_done("load_running_nak");
    check("nak_load_halt", 32'(dl.o_halt), 32'd0);
    exp_tx_q.push_back(8'h15);
    send_byte(8'h7A);
    wait_done("unknown_nak");
    check("nak_unknown_halt", 32'(dl.o_halt), 32'd0);
    exp_tx_q.push_back(8'h15);
    send_byte(8'h53);
    wait_done("step_running_nak");
    check("nak_step_halt", 32'(dl.o_halt), 32'd0);
    check("nak_no_writes", 32'(writes), 32'd2);
    exp_tx_q.push_back(8'h06);
    send_byte(8'h48);
    check("halt_cmd", 32'(dl.o_halt), 32'd1);
    wait_done("halt_done");

    // Asynchronous reset in the middle of a load.
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    #2 rst = 1'b1;
    #1;
    check("midreset_halt",  32'(dl.o_halt), 32'd1);
    check("midreset_write", 32'(dl.o_write_instruction_mem), 32'd0);
    check("midreset_addr",  dl.o_instruction_mem_addr, 32'd0);
    check("midreset_data",  dl.o_instruction_mem_data, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_write(32'h0, 32'h44332211);
    exp_tx_q.push_back(8'h06);
    send_byte(8'h4C); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done("reload_done");
    check("reload_writes", 32'(writes), 32'd3);

    // Count byte 0 means 256 words.
    for (int k = 0; k < 256; k++) begin
      words[k] = $urandom;
      expect_write(32'(k) << 2, words[k]);
    end
    exp_tx_q.push_back(8'h06);
    send_byte(8'h4C); send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      w = words[k];
      send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
    end
    wait_done("load256_done");
    check("load256_writes", 32'(writes), 32'd259);
    check("load256_last_addr", dl.o_instruction_mem_addr, 32'h3FC);
    check("load256_halt", 32'(dl.o_halt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
